// File: rtl/axi_rom_responder_if.sv
// axi_rom_responder_if: AXI4 read-address and read-data channels between a
// fetch master and the ROM responder.
interface axi_rom_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [3:0]            rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_rom_responder.sv
// axi_rom_responder: AXI4 read-only memory responder with a queued AR channel,
// FIXED/INCR bursts, per-beat latency and a side loader write port.
module axi_rom_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'ha000_0000,
    parameter int                    RD_LATENCY = 2,
    parameter int                    REQ_DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    axi_rom_responder_if.slave    bus,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);
    localparam int QW = ADDR_WIDTH + 17;
    localparam int PW = REQ_DEPTH > 1 ? $clog2(REQ_DEPTH) : 1;
    localparam int CW = $clog2(REQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [QW-1:0]         q_mem [REQ_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  arready_q, rvalid_q, rlast_q, slv_q, dec_q, push, pop;
    logic [1:0]            rresp_q, burst_q, resp, h_burst;
    logic [3:0]            rid_q, id_q, cnt_q, h_id;
    logic [7:0]            len_q, beat_q, h_len;
    logic [2:0]            h_size;
    logic [ADDR_WIDTH-1:0] addr_q, h_addr;
    logic [DATA_WIDTH-1:0] rdata_q, word;
    logic [DEPTH_LOG2-1:0] idx;

    function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return a < BASE_ADDR || (off >> (DEPTH_LOG2 + 2)) != '0;
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(REQ_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        {h_addr, h_id, h_len, h_size, h_burst} = q_mem[rd_q];
        push    = bus.arvalid && arready_q;
        pop     = state_q == IDLE && count_q != '0;
        count_d = count_q + CW'(push) - CW'(pop);
        idx     = DEPTH_LOG2'((addr_q - BASE_ADDR) >> 2);
        // a loader write on the same edge as the beat read must be seen
        word    = load_we && load_addr == idx ? load_data : mem[idx];
        resp    = dec_q || oor(addr_q) ? 2'b11 : slv_q ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clock) begin
        if (load_we) mem[load_addr] <= load_data;
        if (push) q_mem[wr_q] <= {bus.araddr, bus.arid, bus.arlen, bus.arsize, bus.arburst};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            slv_q     <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            arready_q <= count_d != CW'(REQ_DEPTH);
            if (push) wr_q <= nxt(wr_q);
            if (pop) rd_q <= nxt(rd_q);
            case (state_q)
                IDLE: if (pop) begin
                    addr_q  <= h_addr;
                    id_q    <= h_id;
                    len_q   <= h_len;
                    burst_q <= h_burst;
                    slv_q   <= h_size != 3'b010 || h_burst[1];
                    dec_q   <= oor(h_addr);
                    beat_q  <= '0;
                    cnt_q   <= 4'(RD_LATENCY);
                    state_q <= WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    state_q  <= DATA;
                    rvalid_q <= 1'b1;
                    rresp_q  <= resp;
                    rdata_q  <= resp == 2'b00 ? word : '0;
                    rlast_q  <= beat_q == len_q;
                    rid_q    <= id_q;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                DATA: if (bus.rready) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (rlast_q) begin
                        state_q <= IDLE;
                    end else begin
                        beat_q  <= beat_q + 1'b1;
                        addr_q  <= burst_q == 2'b01 ? addr_q + ADDR_WIDTH'(4) : addr_q;
                        cnt_q   <= 4'(RD_LATENCY);
                        state_q <= WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
endmodule

// File: tb/tb_axi_rom_responder.sv
// tb_axi_rom_responder: directed bench for the AXI ROM responder with
// hand-computed beats, responses and latencies.
module tb_axi_rom_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_we = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    int cyc = 0, total = 0, bad = 0, t, p, s, h1, t4;

    axi_rom_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

    axi_rom_responder dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input logic [31:0] d);
        load_we = 1'b1;
        load_addr = 10'(i);
        load_data = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst, output int tt);
        bus.arvalid = 1'b1;
        bus.araddr = a;
        bus.arid = id;
        bus.arlen = len;
        bus.arsize = size;
        bus.arburst = burst;
        for (int i = 0; i < 40 && !bus.arready; i++) @(negedge clk);
        chk("arready", bus.arready, 1);
        tt = cyc + 1;
        @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] r,
                        input logic l, input logic [3:0] id, output int seen);
        for (int i = 0; i < 40 && !bus.rvalid; i++) @(negedge clk);
        chk({tag, "_valid"}, bus.rvalid, 1);
        chk({tag, "_data"}, bus.rdata, d);
        chk({tag, "_resp"}, bus.rresp, r);
        chk({tag, "_last"}, bus.rlast, l);
        chk({tag, "_id"}, bus.rid, id);
        seen = cyc;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.arvalid = 1'b0;
        bus.araddr = '0;
        bus.arid = '0;
        bus.arlen = '0;
        bus.arsize = '0;
        bus.arburst = '0;
        bus.rready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_arready", bus.arready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rresp", bus.rresp, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_rdata", bus.rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_arready", bus.arready, 1);
        load(0, 11);
        load(1, 22);
        load(2, 33);
        load(3, 44);
        load(1023, 32'hdeadbeef);

        // INCR burst of four, rready held high
        bus.rready = 1'b1;
        ar(32'ha000_0000, 5, 3, 3'b010, 2'b01, t);
        beat("i0", 11, 2'b00, 0, 5, s);
        chk("lat_first", s - t, 4);
        p = s;
        beat("i1", 22, 2'b00, 0, 5, s);
        chk("lat_beat", s - p, 4);
        beat("i2", 33, 2'b00, 0, 5, s);
        beat("i3", 44, 2'b00, 1, 5, s);
        chk("idle_rvalid", bus.rvalid, 0);

        // FIXED burst with a five-cycle stall on the second beat
        ar(32'ha000_0008, 3, 2, 3'b010, 2'b00, t);
        beat("f0", 33, 2'b00, 0, 3, s);
        bus.rready = 1'b0;
        for (int i = 0; i < 40 && !bus.rvalid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", bus.rvalid, 1);
            chk("hold_data", bus.rdata, 33);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        beat("f1", 33, 2'b00, 0, 3, s);
        beat("f2", 33, 2'b00, 1, 3, s);

        // queue fills while responses are stalled, then drains in order
        bus.rready = 1'b0;
        ar(32'ha000_0000, 1, 0, 3'b010, 2'b01, t);
        p = t;
        ar(32'ha000_0004, 2, 0, 3'b010, 2'b01, t);
        chk("b2b_2", t - p, 1);
        p = t;
        ar(32'ha000_0008, 3, 0, 3'b010, 2'b01, t);
        chk("b2b_3", t - p, 1);
        chk("full_arready", bus.arready, 0);
        fork
            ar(32'ha000_000c, 4, 0, 3'b010, 2'b01, t4);
            begin
                bus.rready = 1'b1;
                beat("q1", 11, 2'b00, 1, 1, h1);
                beat("q2", 22, 2'b00, 1, 2, s);
                chk("q_gap", s - h1, 5);
                beat("q3", 33, 2'b00, 1, 3, s);
                beat("q4", 44, 2'b00, 1, 4, s);
            end
        join
        chk("q4_accept", t4 - h1, 3);

        // error responses
        ar(32'h8000_0000, 6, 0, 3'b010, 2'b01, t);
        beat("dec", 0, 2'b11, 1, 6, s);
        ar(32'ha000_0000, 7, 0, 3'b001, 2'b01, t);
        beat("slv_size", 0, 2'b10, 1, 7, s);
        ar(32'ha000_0000, 11, 0, 3'b010, 2'b10, t);
        beat("slv_wrap", 0, 2'b10, 1, 11, s);

        // INCR running off the end of the array
        ar(32'ha000_0ffc, 8, 3, 3'b010, 2'b01, t);
        beat("x0", 32'hdeadbeef, 2'b00, 0, 8, s);
        beat("x1", 0, 2'b11, 0, 8, s);
        beat("x2", 0, 2'b11, 0, 8, s);
        beat("x3", 0, 2'b11, 1, 8, s);

        // reset in the middle of a burst
        ar(32'ha000_0000, 9, 3, 3'b010, 2'b01, t);
        beat("r0", 11, 2'b00, 0, 9, s);
        for (int i = 0; i < 40 && !bus.rvalid; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid", bus.rvalid, 0);
        chk("mid_arready", bus.arready, 0);
        chk("mid_rlast", bus.rlast, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_arready", bus.arready, 1);
        chk("post_rvalid", bus.rvalid, 0);
        ar(32'ha000_0004, 10, 1, 3'b010, 2'b01, t);
        beat("n0", 22, 2'b00, 0, 10, s);
        beat("n1", 33, 2'b00, 1, 10, s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
